// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller inport.
// An in-order tag FIFO routes each controller ack and its read data back to the issuing master.
module sdram_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [3:0]  m0_wr_i,
    input  logic        m0_rd_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_write_data_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic [31:0] m0_read_data_o,

    input  logic [3:0]  m1_wr_i,
    input  logic        m1_rd_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_write_data_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic [31:0] m1_read_data_o,

    output logic [3:0]  outport_wr_o,
    output logic        outport_rd_o,
    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_write_data_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic [31:0] outport_read_data_i,

    output logic [CNT_W-1:0] outstanding_o,
    output logic             error_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Arbitration state: last granted master and the mid-handshake grant lock.
    logic             r_last;
    logic             r_lock;
    logic             r_grant;
    logic             r_error;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_tag_mem [MAX_OUTSTANDING];

    logic w_req0;
    logic w_req1;
    logic w_sel_valid;
    logic w_sel;
    logic w_blocked;
    logic w_fire;
    logic w_ack_any;
    logic w_pop;
    logic w_stray;
    logic w_head;

    assign w_req0    = m0_rd_i | (|m0_wr_i);
    assign w_req1    = m1_rd_i | (|m1_wr_i);
    assign w_blocked = (r_count == CNT_W'(MAX_OUTSTANDING));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = 1'b0;
        if (r_lock) begin
            w_sel       = r_grant;
            w_sel_valid = r_grant ? w_req1 : w_req0;
        end else if (w_req0 && w_req1) begin
            w_sel_valid = 1'b1;
            w_sel       = ~r_last;
        end else if (w_req0) begin
            w_sel_valid = 1'b1;
            w_sel       = 1'b0;
        end else if (w_req1) begin
            w_sel_valid = 1'b1;
            w_sel       = 1'b1;
        end
    end

    // Address and data follow the selected master even while blocked; the strobes do not.
    always_comb begin
        outport_wr_o         = 4'b0;
        outport_rd_o         = 1'b0;
        outport_addr_o       = 32'b0;
        outport_write_data_o = 32'b0;
        if (w_sel_valid) begin
            outport_addr_o       = w_sel ? m1_addr_i       : m0_addr_i;
            outport_write_data_o = w_sel ? m1_write_data_i : m0_write_data_i;
            if (!w_blocked) begin
                outport_wr_o = w_sel ? m1_wr_i : m0_wr_i;
                outport_rd_o = w_sel ? m1_rd_i : m0_rd_i;
            end
        end
    end

    assign w_fire      = (outport_rd_o | (|outport_wr_o)) & outport_accept_i & ~rst_i;
    assign m0_accept_o = w_fire & ~w_sel;
    assign m1_accept_o = w_fire &  w_sel;

    assign w_head    = r_tag_mem[r_rd_ptr];
    assign w_ack_any = outport_ack_i & ~rst_i;
    assign w_pop     = w_ack_any & (r_count != '0);
    assign w_stray   = w_ack_any & (r_count == '0);

    assign m0_ack_o       = w_pop & ~w_head;
    assign m1_ack_o       = w_pop &  w_head;
    assign m0_read_data_o = outport_read_data_i;
    assign m1_read_data_o = outport_read_data_i;

    assign outstanding_o = r_count;
    assign error_o       = r_error;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last  <= 1'b1;
            r_lock  <= 1'b0;
            r_grant <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_fire) begin
                r_last <= w_sel;
                r_lock <= 1'b0;
            end else if (w_sel_valid && !w_blocked) begin
                r_lock  <= 1'b1;
                r_grant <= w_sel;
            end
            if (w_stray) begin
                r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: tag storage has no reset; entries are only read between valid pointers, which are reset.
    always_ff @(posedge clk_i) begin
        if (w_fire) begin
            r_tag_mem[r_wr_ptr] <= w_sel;
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-master request arbiter that sits directly upstream of the SDRAM controller's inport.
- Merges a CPU port (m0) and a DMA port (m1) onto the single inport using round-robin arbitration with grant locking.
- Tracks the master of each accepted request in an in-order tag FIFO, so each controller ack and its read data go back to the master that issued the request.

Parameters:
- MAX_OUTSTANDING, 4, depth of the tag FIFO and the maximum number of accepted-but-unacked requests (power of 2, minimum 2).
- CNT_W, 3, width of outstanding_o; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- m0_wr_i  in  4  master 0 byte write strobes
- m0_rd_i  in  1  master 0 read request
- m0_addr_i  in  32  master 0 address
- m0_write_data_i  in  32  master 0 write data
- m0_accept_o  out  1  master 0 request accepted this cycle
- m0_ack_o  out  1  master 0 completion
- m0_read_data_o  out  32  master 0 read data
- m1_* : same seven signals for master 1
- outport_wr_o  out  4  to controller inport_wr_i
- outport_rd_o  out  1  to controller inport_rd_i
- outport_addr_o  out  32  to controller inport_addr_i
- outport_write_data_o  out  32  to controller inport_write_data_i
- outport_accept_i  in  1  from controller inport_accept_o
- outport_ack_i  in  1  from controller inport_ack_o
- outport_read_data_i  in  32  from controller inport_read_data_o
- outstanding_o  out  CNT_W  current tag FIFO occupancy
- error_o  out  1  sticky protocol error

Behaviour:
- Request detection: reqN = mN_rd_i | (|mN_wr_i).
- Master rule: a master holds its request stable until it sees its accept.
- Reset values:
  - last_q = 1, so m0 wins the first contention.
  - lock_q = 0, grant_q = 0.
  - FIFO empty: wr_ptr = rd_ptr = 0, count = 0.
  - error_o = 0, outstanding_o = 0.
- Outputs are combinational from registered state and inputs:
  - no accept, ack or error_o pulses while rst_i is high;
  - all outport_* are 0 while no master is selected.
- Selection:
  - If lock_q is set, sel = grant_q.
  - Otherwise, if both masters request, sel = ~last_q.
  - Otherwise sel is whichever master requests.
  - Otherwise no master is selected.
- Blocking: when count == MAX_OUTSTANDING, outport_wr_o = 0 and outport_rd_o = 0, and no accept is given.
- Outport: when not blocked, outport_* carry the selected master's wr/rd/addr/write_data. addr and write_data are 0 when no master is selected.
- Accept: fire = (outport_rd_o | |outport_wr_o) & outport_accept_i.
  - m{sel}_accept_o = fire; the other accept is 0.
  - On fire: push sel into the FIFO, set last_q <= sel, clear lock_q.
- Lock: valid request, not accepted and not blocked → lock_q <= 1 and grant_q <= sel.
  - Effect: the grant cannot switch masters mid-handshake.
- Ack routing: on outport_ack_i with count > 0:
  - pop the FIFO head;
  - mH_ack_o = 1 for head H; the other ack is 0 in the same cycle.
- Read data: outport_read_data_i drives both mN_read_data_o unconditionally; masters qualify it with their ack.
- Simultaneous push and pop in one cycle: count is unchanged, and both pointers advance modulo MAX_OUTSTANDING.
- Blocked FIFO + same-cycle ack: blocking is evaluated on the registered count, so the next request can be accepted one cycle after the pop.
- Stray ack: outport_ack_i with count == 0:
  - no master ack, no pop;
  - error_o <= 1 and stays set until reset.
- Reset mid-operation: FIFO, lock and error are cleared asynchronously. Acks arriving after reset release are treated as stray.
- outstanding_o = count.

Test Plan:
- Only m0 issues a read to addr 0x100, accept_i high → m0_accept_o = 1 same cycle, outport_rd_o = 1, outport_addr_o = 0x100; later ack_i with data 0xDEADBEEF → m0_ack_o = 1, m0_read_data_o = 0xDEADBEEF, m1_ack_o = 0.
- Both masters request continuously, accept_i always high → grants alternate m0, m1, m0, m1 (m0 first after reset); outstanding_o rises by one per accept.
- m1 requests with accept_i low for 3 cycles while m0 asserts in cycle 2 → outport keeps m1's address all 3 cycles; m1 is accepted first, m0 next.
- Accept 4 requests with no acks → outstanding_o = 4, outport_rd_o/wr_o = 0, no accepts; one ack → next cycle the pending request is accepted, outstanding_o = 4.
- Order m0 write, m1 read, m0 read, then 3 acks → ack sequence m0, m1, m0; push and pop in the same cycle leaves outstanding_o unchanged.
- ack_i with FIFO empty → no mN_ack_o, error_o = 1 and stays high; assert rst_i mid-traffic → outstanding_o = 0 and error_o = 0 immediately.
